// File: rtl/uart_bus_bridge.sv
// ---------------------------------------------------------------------------
// uart_bus_bridge
//   Debug bridge that turns 8N1 serial command frames into single 32-bit bus
//   transactions and returns a status byte (plus read data) on its own
//   serial transmitter.
//
//   Frames from the host:
//     'W' (0x57) A3 A2 A1 A0 D3 D2 D1 D0   -> bus write, reply 'K'
//     'R' (0x52) A3 A2 A1 A0               -> bus read,  reply 'K' D3..D0
//   Address and data bytes are MSB first; A[1:0] is dropped (word address).
//
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   uart_txd_in   serial input from host (asynchronous, idle high)
//   uart_rxd_out  serial output to host (idle high)
//   bus_o         master request (addr, data, cyc, stb, we, sel)
//   bus_i         slave response (ack, data)
//
// Parameters:
//   DIVIDE       clocks per UART bit, must be >= 4
//   ACK_TIMEOUT  clocks to wait for ack before aborting (BRIDGE_TIMEOUT_EN)
//
// Optional feature macro: BRIDGE_TIMEOUT_EN
//   When defined, a stalled bus cycle is abandoned after ACK_TIMEOUT clocks
//   and the host receives 'E' (0x45) with no data bytes.
// ---------------------------------------------------------------------------
package bus;
  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
  } m2s_s;

  typedef struct packed {
    logic        ack;
    logic [31:0] data;
  } s2m_s;
endpackage

module uart_bus_bridge #(
  parameter int unsigned DIVIDE      = 32,
  parameter int unsigned ACK_TIMEOUT = 1024
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      uart_txd_in,
  output logic      uart_rxd_out,
  output bus::m2s_s bus_o,
  input  bus::s2m_s bus_i
);

  localparam int unsigned CW = $clog2(DIVIDE);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIVIDE - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIVIDE / 2 - 1);

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_OK    = 8'h4B;
  localparam logic [7:0] RSP_ERR   = 8'h45;

  // Reject configurations the bit timing cannot support.
  if (DIVIDE < 4 || ACK_TIMEOUT < 1) begin : g_bad_params
    $error("uart_bus_bridge: DIVIDE must be >= 4 and ACK_TIMEOUT >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS,
    S_STATUS,
    S_RDATA
  } state_t;

  // Receiver state
  logic [1:0]    r_rx_sync;
  logic          r_rx_last;
  logic          r_rx_busy;
  logic [CW-1:0] r_rx_cnt;
  logic [3:0]    r_rx_phase;
  logic [7:0]    r_rx_shift;
  logic          r_rx_valid;

  // Transmitter state
  logic          r_tx_busy;
  logic          r_txd;
  logic [CW-1:0] r_tx_cnt;
  logic [3:0]    r_tx_bit;
  logic [8:0]    r_tx_shift;
  logic          w_tx_start;
  logic [7:0]    w_tx_data;

  // Command FSM state
  state_t        r_state;
  logic          r_is_write;
  logic [1:0]    r_byte_cnt;
  logic [31:0]   r_addr;
  logic [23:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic [29:0]   r_bus_addr;
  logic [31:0]   r_bus_data;
  logic          r_cyc;
  logic          r_stb;
  logic          r_we;
  logic [3:0]    r_sel;
  logic          w_fail;

  logic [31:0]   w_addr_next;
  logic [31:0]   w_wdata_next;

`ifdef BRIDGE_TIMEOUT_EN
  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);
  logic [TW-1:0] r_to_cnt;
  logic          r_err;
  assign w_fail = r_err;
`else
  assign w_fail = 1'b0;
`endif

  assign w_addr_next  = {r_addr[23:0], r_rx_shift};
  assign w_wdata_next = {r_wdata, r_rx_shift};

  assign uart_rxd_out = r_txd;
  assign bus_o = '{addr: r_bus_addr, data: r_bus_data, cyc: r_cyc,
                   stb: r_stb, we: r_we, sel: r_sel};

  // Serial receiver: synchronise, find start edge, sample mid-bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_sync  <= 2'b11;
      r_rx_last  <= 1'b1;
      r_rx_busy  <= 1'b0;
      r_rx_cnt   <= {CW{1'b0}};
      r_rx_phase <= 4'd0;
      r_rx_shift <= 8'h00;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_sync  <= {r_rx_sync[0], uart_txd_in};
      r_rx_last  <= r_rx_sync[1];
      r_rx_valid <= 1'b0;
      if (!r_rx_busy) begin
        if (r_rx_last && !r_rx_sync[1]) begin
          r_rx_busy  <= 1'b1;
          r_rx_cnt   <= HALF_LAST;
          r_rx_phase <= 4'd0;
        end
      end else if (r_rx_cnt != {CW{1'b0}}) begin
        r_rx_cnt <= r_rx_cnt - 1'b1;
      end else begin
        r_rx_cnt   <= BIT_LAST;
        r_rx_phase <= r_rx_phase + 4'd1;
        if (r_rx_phase == 4'd0) begin
          // A start bit that is high again at mid-bit was only a glitch.
          if (r_rx_sync[1]) begin
            r_rx_busy <= 1'b0;
          end
        end else if (r_rx_phase == 4'd9) begin
          // Stop bit low means a framing error: the byte just vanishes.
          r_rx_busy  <= 1'b0;
          r_rx_valid <= r_rx_sync[1];
        end else begin
          r_rx_shift <= {r_rx_sync[1], r_rx_shift[7:1]};
        end
      end
    end
  end

  // Serial transmitter: start, 8 data bits LSB first, stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_busy  <= 1'b0;
      r_txd      <= 1'b1;
      r_tx_cnt   <= {CW{1'b0}};
      r_tx_bit   <= 4'd0;
      r_tx_shift <= 9'h1FF;
    end else if (!r_tx_busy) begin
      if (w_tx_start) begin
        r_tx_busy  <= 1'b1;
        r_txd      <= 1'b0;
        r_tx_shift <= {1'b1, w_tx_data};
        r_tx_cnt   <= BIT_LAST;
        r_tx_bit   <= 4'd0;
      end else begin
        r_txd <= 1'b1;
      end
    end else if (r_tx_cnt != {CW{1'b0}}) begin
      r_tx_cnt <= r_tx_cnt - 1'b1;
    end else if (r_tx_bit == 4'd9) begin
      // Stop bit has run its full length; free in time for a back-to-back start.
      r_tx_busy <= 1'b0;
    end else begin
      r_txd      <= r_tx_shift[0];
      r_tx_shift <= {1'b1, r_tx_shift[8:1]};
      r_tx_bit   <= r_tx_bit + 4'd1;
      r_tx_cnt   <= BIT_LAST;
    end
  end

  // Pick the next reply byte whenever the transmitter is free.
  always_comb begin
    w_tx_start = 1'b0;
    w_tx_data  = 8'h00;
    if (!r_tx_busy) begin
      case (r_state)
        S_STATUS: begin
          w_tx_start = 1'b1;
          w_tx_data  = w_fail ? RSP_ERR : RSP_OK;
        end
        S_RDATA: begin
          w_tx_start = 1'b1;
          w_tx_data  = r_rdata[31:24];
        end
        default: begin
          w_tx_start = 1'b0;
          w_tx_data  = 8'h00;
        end
      endcase
    end else begin
      w_tx_start = 1'b0;
      w_tx_data  = 8'h00;
    end
  end

  // Command decoder, bus master and reply sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_is_write <= 1'b0;
      r_byte_cnt <= 2'd0;
      r_addr     <= 32'h0000_0000;
      r_wdata    <= 24'h00_0000;
      r_rdata    <= 32'h0000_0000;
      r_bus_addr <= 30'h0000_0000;
      r_bus_data <= 32'h0000_0000;
      r_cyc      <= 1'b0;
      r_stb      <= 1'b0;
      r_we       <= 1'b0;
      r_sel      <= 4'h0;
`ifdef BRIDGE_TIMEOUT_EN
      r_to_cnt   <= {TW{1'b0}};
      r_err      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_rx_valid && (r_rx_shift == CMD_WRITE || r_rx_shift == CMD_READ)) begin
            r_is_write <= (r_rx_shift == CMD_WRITE);
            r_byte_cnt <= 2'd0;
            r_state    <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (r_rx_valid) begin
            r_addr     <= w_addr_next;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              if (r_is_write) begin
                r_state <= S_DATA;
              end else begin
                r_state    <= S_BUS;
                r_bus_addr <= w_addr_next[31:2];
                r_bus_data <= 32'h0000_0000;
                r_cyc      <= 1'b1;
                r_stb      <= 1'b1;
                r_we       <= 1'b0;
                r_sel      <= 4'hF;
`ifdef BRIDGE_TIMEOUT_EN
                r_to_cnt   <= {TW{1'b0}};
                r_err      <= 1'b0;
`endif
              end
            end
          end
        end
        S_DATA: begin
          if (r_rx_valid) begin
            r_wdata    <= w_wdata_next[23:0];
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_state    <= S_BUS;
              r_bus_addr <= r_addr[31:2];
              r_bus_data <= w_wdata_next;
              r_cyc      <= 1'b1;
              r_stb      <= 1'b1;
              r_we       <= 1'b1;
              r_sel      <= 4'hF;
`ifdef BRIDGE_TIMEOUT_EN
              r_to_cnt   <= {TW{1'b0}};
              r_err      <= 1'b0;
`endif
            end
          end
        end
        S_BUS: begin
          if (bus_i.ack) begin
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_rdata <= bus_i.data;
            r_state <= S_STATUS;
`ifdef BRIDGE_TIMEOUT_EN
          end else if (r_to_cnt == TO_LAST) begin
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_err   <= 1'b1;
            r_state <= S_STATUS;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
`else
          end else begin
            r_state <= S_BUS;
`endif
          end
        end
        S_STATUS: begin
          if (!r_tx_busy) begin
            r_byte_cnt <= 2'd0;
            r_state    <= (r_is_write || w_fail) ? S_IDLE : S_RDATA;
          end
        end
        S_RDATA: begin
          if (!r_tx_busy) begin
            r_rdata    <= {r_rdata[23:0], 8'h00};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_bus_bridge.md
Name: uart_bus_bridge

Overview:
UART-to-bus debug bridge; a bus master driven by byte commands received on a serial line. Decodes 8N1 read/write frames, issues single 32-bit bus transactions, and returns status and read data over its own UART transmitter. Attaches as a master port on bus_intercon, so a host or bench can reach any mapped slave, including uart_bus, without a CPU.

Parameters:
DIVIDE, 32, clocks per UART bit (≥4); fixed, no runtime register
ACK_TIMEOUT, 1024, clocks to wait for bus ack before aborting (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
uart_txd_in  in  1  serial input from host, idle high, asynchronous
uart_rxd_out  out  1  serial output to host, idle high
bus_o  out  bus::m2s_s  master request: addr[29:0] word address, data, cyc, stb, we, sel
bus_i  in  bus::s2m_s  slave response: ack, data

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. Reset values: uart_rxd_out=1; bus_o.cyc=stb=we=0; addr=0; data=0; sel=0; FSM=IDLE; RX and TX idle.
- RX: 2-flop synchronizer on uart_txd_in. A falling edge starts a frame. Sample start bit at DIVIDE/2; if the sample is 1, treat as a glitch and return to idle. Sample 8 data bits LSB first at DIVIDE spacing, then the stop bit. Stop=0 is a framing error: drop the byte with no other effect. Each good byte produces a 1-clock rx_valid.
- TX: 8N1, LSB first, DIVIDE clocks per bit. Accepts a byte only when idle. Back-to-back bytes have no extra idle bits.
- Command frame: cmd byte, then A3..A0 (32-bit byte address, MSB first). A write adds D3..D0 (MSB first).
- Commands: 0x57 'W' write, 0x52 'R' read. Any other cmd byte is ignored and the FSM stays in IDLE.
- FSM states:
  - IDLE: on cmd 'W' or 'R', go to ADDR with byte count=0.
  - ADDR: shift in 4 bytes. After the 4th, 'W' goes to DATA and 'R' goes to BUS.
  - DATA: shift in 4 bytes, then go to BUS.
  - BUS: drive cyc=stb=1, addr=A[31:2], sel=4'hF, we=1 for 'W', data=D. Hold all until the first cycle with bus_i.ack=1, then capture bus_i.data on a read. Deassert cyc/stb/we on the next clock. A[1:0] is ignored.
  - STATUS: send 0x4B 'K' on success. A read continues to RDATA; a write returns to IDLE.
  - RDATA: send captured data MSB first (4 bytes), then IDLE.
- Bus latency: cyc/stb assert on the clock after the last command byte's rx_valid. The transaction takes at least 1 cycle.
- RX bytes that arrive while the FSM is in BUS, STATUS or RDATA are discarded. The host must wait for the full response.
- A framing error mid-command does not abort the command. The byte is simply not counted.
- Reset mid-transaction drops cyc/stb on the next clock edge, aborts TX, and leaves uart_rxd_out high.
- Address wrap: A=0xFFFFFFFC gives addr=30'h3FFFFFFF. No special handling.

Optional Feature:
Macro BRIDGE_TIMEOUT_EN.
- Defined: a counter runs in BUS. If ACK_TIMEOUT clocks pass without ack, drop cyc/stb, send 0x45 'E' and no data bytes, then return to IDLE. A late ack after abort is ignored.
- Undefined: BUS waits for ack indefinitely and the counter logic is absent.

Test Plan:
- Reset: hold rst 5 cycles → uart_rxd_out=1, cyc=stb=we=0, sel=0 throughout and on release.
- Write: host sends 57 00 00 04 08 00 00 00 20 → exactly one cycle-accepted bus write, addr=30'h102, data=32'h20, sel=F, we=1 → host receives 4B. With uart_bus attached, its divider reads back 0x20.
- Read: memory model at byte addr 0x1000 holds 0xDEADBEEF, host sends 52 00 00 10 00 → read addr=30'h400, we=0 → host receives 4B DE AD BE EF.
- Wait-state slave: ack delayed 7 cycles on a write → cyc/stb/addr/data stable all 7 cycles, single ack consumed, response 4B.
- Robustness: 1-clock low glitch on uart_txd_in, then byte 0x33, then a byte with stop bit 0, then a valid read → no bus activity until the read, which completes normally.
- BRIDGE_TIMEOUT_EN with ACK_TIMEOUT=16: read to an address with ack tied 0 → cyc drops after 16 cycles, host receives 45 only. Following read to a good slave returns 4B plus data.
